// File: rtl/hazard_pkg.sv
// Shared types and parameter checks for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // MDU FSM state encoding kept as plain constants for legacy tools
    typedef logic [0:0] mdu_state_t;
    localparam mdu_state_t IDLE = 1'b0;
    localparam mdu_state_t BUSY = 1'b1;

    localparam int unsigned NUM_RS_MIN  = 2;
    localparam int unsigned NUM_RS_MAX  = 3;
    localparam int unsigned MDU_LAT_MIN = 2;
    localparam int unsigned MDU_LAT_MAX = 16;

    function automatic bit params_ok(input int unsigned reg_aw,
                                     input int unsigned num_rs,
                                     input int unsigned mdu_lat);
        return (reg_aw >= 1) &&
               (num_rs >= NUM_RS_MIN) && (num_rs <= NUM_RS_MAX) &&
               (mdu_lat >= MDU_LAT_MIN) && (mdu_lat <= MDU_LAT_MAX);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// One execute-stage operand: compare against M/W destinations, M wins over W.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              en_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic [REG_AW-1:0] rs_i,
    output logic [1:0]        sel_o
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (en_i) begin
            if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
                sel = FWD_M;
            end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
                sel = FWD_W;
            end
        end
    end

    assign sel_o = sel;

endmodule

// File: rtl/fwd_stall_unit.sv
// Hazard controller: operand forwarding, load-use stall, branch flush and MDU hold.
// Optional MDU stall FSM is compiled in with HAZARD_MDU_EN.
module fwd_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_RS  = 2,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic                     MemReadE,
    input  logic                     MduStartE,
    input  logic                     PCSrcE,
    input  logic [REG_AW-1:0]        RD_E,
    input  logic [REG_AW-1:0]        RD_M,
    input  logic [REG_AW-1:0]        RD_W,
    input  logic [NUM_RS*REG_AW-1:0] Rs_D,
    input  logic [NUM_RS*REG_AW-1:0] Rs_E,
    output logic [NUM_RS*2-1:0]      ForwardE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushM,
    output logic                     MduBusy
);

    localparam int unsigned CNT_W = $clog2(MDU_LAT);

    if (!params_ok(REG_AW, NUM_RS, MDU_LAT)) begin : g_bad_params
        $error("fwd_stall_unit: parameter out of range");
    end

    logic load_use;
    logic mdu_stall;
    logic mdu_busy;

    for (genvar i = 0; i < int'(NUM_RS); i++) begin : g_fwd
        fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
            .en_i          (rst),
            .reg_write_m_i (RegWriteM),
            .reg_write_w_i (RegWriteW),
            .rd_m_i        (RD_M),
            .rd_w_i        (RD_W),
            .rs_i          (Rs_E[i*REG_AW +: REG_AW]),
            .sel_o         (ForwardE[i*2 +: 2])
        );
    end

    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            if (Rs_D[i*REG_AW +: REG_AW] == RD_E) begin
                load_use = 1'b1;
            end
        end
        load_use = load_use && MemReadE && (RD_E != '0);
    end

`ifdef HAZARD_MDU_EN
    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The final BUSY cycle (cnt==0) releases the stall and ignores a new start
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MduStartE) begin
                    mdu_stall = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(MDU_LAT - 2);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mdu_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdu_busy = (state_q == BUSY);
`else
    logic [1:0] unused_mdu;

    assign unused_mdu = {MduStartE, clk};
    assign mdu_stall  = 1'b0;
    assign mdu_busy   = 1'b0;
`endif

    // MDU hold beats branch, branch beats load-use; everything low in reset
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (rst) begin
            if (mdu_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MduBusy = mdu_busy && rst;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench for fwd_stall_unit; MDU sequences run when HAZARD_MDU_EN is defined.
module tb_fwd_stall_unit;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned NUM_RS  = 2;
    localparam int unsigned MDU_LAT = 4;
    localparam int          NVEC    = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     RegWriteM, RegWriteW, MemReadE, MduStartE, PCSrcE;
    logic [REG_AW-1:0]        RD_E, RD_M, RD_W;
    logic [NUM_RS*REG_AW-1:0] Rs_D, Rs_E;
    logic [NUM_RS*2-1:0]      ForwardE;
    logic                     StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_stall_unit #(.REG_AW(REG_AW), .NUM_RS(NUM_RS), .MDU_LAT(MDU_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .MemReadE  (MemReadE),
        .MduStartE (MduStartE),
        .PCSrcE    (PCSrcE),
        .RD_E      (RD_E),
        .RD_M      (RD_M),
        .RD_W      (RD_W),
        .Rs_D      (Rs_D),
        .Rs_E      (Rs_E),
        .ForwardE  (ForwardE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushM    (FlushM),
        .MduBusy   (MduBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rwm, rww, memr, pcsrc;
        logic [4:0] rd_e, rd_m, rd_w;
        logic [9:0] rs_d, rs_e;
        logic [3:0] fwd;
        logic       sf, sd, fd, fe;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] fwd,
                             input logic sf, input logic sd, input logic se,
                             input logic fd, input logic fe, input logic fm,
                             input logic mb);
        chk({tag, ".ForwardE"}, 8'(ForwardE), 8'(fwd));
        chk({tag, ".StallF"},   8'(StallF),   8'(sf));
        chk({tag, ".StallD"},   8'(StallD),   8'(sd));
        chk({tag, ".StallE"},   8'(StallE),   8'(se));
        chk({tag, ".FlushD"},   8'(FlushD),   8'(fd));
        chk({tag, ".FlushE"},   8'(FlushE),   8'(fe));
        chk({tag, ".FlushM"},   8'(FlushM),   8'(fm));
        chk({tag, ".MduBusy"},  8'(MduBusy),  8'(mb));
    endtask

    task automatic clear_inputs();
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0;
        MduStartE = 1'b0; PCSrcE = 1'b0;
        RD_E = '0; RD_M = '0; RD_W = '0; Rs_D = '0; Rs_E = '0;
    endtask

    task automatic set_load_use_branch(input logic on);
        MemReadE = on;
        PCSrcE   = on;
        RD_E     = on ? 5'd7 : 5'd0;
        Rs_D     = on ? {5'd7, 5'd1} : 10'd0;
    endtask

`ifdef HAZARD_MDU_EN
    // One MDU op: start held while stalled; branch and load-use injected mid-BUSY
    task automatic run_mdu(input string tag, input logic inject);
        for (int k = 0; k < int'(MDU_LAT); k++) begin
            @(posedge clk); #1;
            MduStartE = 1'b1;
            set_load_use_branch(inject && (k >= 1) && (k < int'(MDU_LAT) - 1));
            @(negedge clk);
            check_all($sformatf("%s.c%0d", tag, k), 4'b0000,
                      k < int'(MDU_LAT) - 1, k < int'(MDU_LAT) - 1, k < int'(MDU_LAT) - 1,
                      1'b0, 1'b0, k < int'(MDU_LAT) - 1, k > 0);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rwm   rww   memr  pcsrc rd_e   rd_m   rd_w   rs_d            rs_e            fwd      sf    sd    fd    fe
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 10'd0,          {5'd0, 5'd5},   4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 10'd0,          {5'd0, 5'd5},   4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 10'd0,          {5'd0, 5'd5},   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd5, 10'd0,          {5'd5, 5'd3},   4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd3, 10'd0,          {5'd3, 5'd3},   4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, {5'd7, 5'd1},   10'd0,          4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, {5'd0, 5'd1},   10'd0,          4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, {5'd7, 5'd1},   10'd0,          4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 10'd0,          10'd0,          4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, {5'd2, 5'd7},   10'd0,          4'b0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, {5'd2, 5'd7},   10'd0,          4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd0, {5'd4, 5'd9},   {5'd9, 5'd9},   4'b1010, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b0;
        clear_inputs();
        #2;
        // Everything gated low in reset even with hazards and forwarding present
        RegWriteM = 1'b1; RD_M = 5'd5; Rs_E = {5'd5, 5'd5};
        set_load_use_branch(1'b1);
        PCSrcE = 1'b0;
        MduStartE = 1'b1;
        #1;
        check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            @(posedge clk); #1;
            RegWriteM = vecs[v].rwm;  RegWriteW = vecs[v].rww;
            MemReadE  = vecs[v].memr; PCSrcE    = vecs[v].pcsrc;
            RD_E = vecs[v].rd_e; RD_M = vecs[v].rd_m; RD_W = vecs[v].rd_w;
            Rs_D = vecs[v].rs_d; Rs_E = vecs[v].rs_e;
            MduStartE = 1'b0;
            @(negedge clk);
            check_all($sformatf("vec%0d", v), vecs[v].fwd, vecs[v].sf, vecs[v].sd, 1'b0,
                      vecs[v].fd, vecs[v].fe, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        clear_inputs();

`ifdef HAZARD_MDU_EN
        run_mdu("mdu_a", 1'b1);
        run_mdu("mdu_b2b", 1'b0);
        @(posedge clk); #1;
        MduStartE = 1'b0;
        @(negedge clk);
        check_all("mdu_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in BUSY cycle 1 drops everything immediately
        @(posedge clk); #1;
        MduStartE = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_all("rst_pre", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        rst = 1'b0;
        RegWriteM = 1'b1; RD_M = 5'd5; Rs_E = {5'd0, 5'd5};
        #1;
        check_all("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        run_mdu("mdu_post_rst", 1'b0);
        @(posedge clk); #1;
        MduStartE = 1'b0;
        @(negedge clk);
        check_all("post_rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        // Without the MDU FSM a start request has no effect on any output
        for (int k = 0; k < int'(MDU_LAT); k++) begin
            @(posedge clk); #1;
            MduStartE = 1'b1;
            PCSrcE = (k == 1);
            @(negedge clk);
            check_all($sformatf("nomdu.c%0d", k), 4'b0000, 1'b0, 1'b0, 1'b0,
                      k == 1, k == 1, 1'b0, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
